quad_gate_checker: RTL and testbench

Synthesizable self-test engine for quad 2-input gate packages (SN74LS32-class OR and its AND/NAND/NOR/XOR siblings). It drives the package's A/B input pins with the four exhaustive input vectors, waits a programmable settle time, and samples the Y pins. It compares each sample against the expected function and reports pass/fail, an error count and the first failing vector. It sits on the opposite side of the gate-package interface: it is the consumer of Y and the producer of A/B, used for on-board bring-up of the logic-chip models.

---
 rtl/quad_gate_checker.sv | 158 +++++++++++++++
 tb/tb_quad_gate_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/quad_gate_checker.sv
// Self-test sequencer for a quad 2-input gate package: walks the four input
// vectors on A/B, waits SETTLE_CYCLES per vector, and grades the Y response.
module quad_gate_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned GATE_FN       = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    output logic [3:0] A,
    output logic [3:0] B,
    input  logic [3:0] Y,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [4:0] ERR_COUNT,
    output logic [1:0] FAIL_VEC,
    output logic [3:0] FAIL_MASK
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

    state_e     state_q, state_d;
    logic [1:0] v_q, v_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic [1:0] fvec_q, fvec_d;
    logic [3:0] fmask_q, fmask_d;
    logic       ffail_q, ffail_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       exp_bit;
    logic [3:0] mismatch;
    logic [2:0] mis_cnt;
    logic [1:0] v_nx;

    function automatic logic gate_eval(input logic a, input logic b);
        case (GATE_FN)
            1:       return a & b;
            2:       return ~(a & b);
            3:       return ~(a | b);
            4:       return a ^ b;
            default: return a | b;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        v_d      = v_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        pass_d   = pass_q;
        fvec_d   = fvec_q;
        fmask_d  = fmask_q;
        ffail_d  = ffail_q;
        a_d      = a_q;
        b_d      = b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        v_nx     = v_q + 2'd1;
        exp_bit  = gate_eval(v_q[1], v_q[0]);
        mismatch = Y ^ {4{exp_bit}};
        mis_cnt  = {2'b0, mismatch[0]} + {2'b0, mismatch[1]}
                 + {2'b0, mismatch[2]} + {2'b0, mismatch[3]};

        case (state_q)
            S_IDLE: begin
                a_d    = '0;
                b_d    = '0;
                busy_d = 1'b0;
                if (START) begin
                    state_d = S_RUN;
                    v_d     = '0;
                    cnt_d   = 4'd1;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    fvec_d  = '0;
                    fmask_d = '0;
                    ffail_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (cnt_q == 4'(SETTLE_CYCLES)) begin
                    err_d = err_q + {2'b0, mis_cnt};
                    if ((mismatch != '0) && !ffail_q) begin
                        fvec_d  = v_q;
                        fmask_d = mismatch;
                        ffail_d = 1'b1;
                    end
                    if (v_q != 2'd3) begin
                        v_d   = v_nx;
                        cnt_d = 4'd1;
                        a_d   = {4{v_nx[1]}};
                        b_d   = {4{v_nx[0]}};
                    end else begin
                        // PASS must reflect this final compare, so grade the updated count
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        a_d     = '0;
                        b_d     = '0;
                        pass_d  = (err_d == '0);
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            v_q     <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            fvec_q  <= '0;
            fmask_q <= '0;
            ffail_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            fvec_q  <= fvec_d;
            fmask_q <= fmask_d;
            ffail_q <= ffail_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign ERR_COUNT = err_q;
    assign FAIL_VEC  = fvec_q;
    assign FAIL_MASK = fmask_q;

endmodule

// File: tb/tb_quad_gate_checker.sv
// Directed bench: OR checker against good/faulty gate models, plus NAND
// checkers facing a one-cycle-lagged gate model at two settle times.
module tb_quad_gate_checker;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST = 1'b1;
    logic st_or = 1'b0, st_n2 = 1'b0, st_n1 = 1'b0;
    int   mode = 0;

    logic [3:0] a_or, b_or, y_or, a_n2, b_n2, y_n2, a_n1, b_n1, y_n1;
    logic       busy_or, done_or, pass_or, busy_n2, done_n2, pass_n2, busy_n1, done_n1, pass_n1;
    logic [4:0] err_or, err_n2, err_n1;
    logic [1:0] fvec_or, fvec_n2, fvec_n1;
    logic [3:0] fmask_or, fmask_n2, fmask_n1;

    // Gate models: 0 good OR, 1 OR with gate 3 output stuck low, else AND
    always_comb begin
        case (mode)
            0:       y_or = a_or | b_or;
            1:       y_or = (a_or | b_or) & 4'b1011;
            default: y_or = a_or & b_or;
        endcase
    end

    // Registered NAND models; they start at 0 and only track while their checker runs
    always @(posedge CLK) begin
        if (RST) begin
            y_n2 <= '0;
            y_n1 <= '0;
        end else begin
            if (busy_n2) y_n2 <= ~(a_n2 & b_n2);
            if (busy_n1) y_n1 <= ~(a_n1 & b_n1);
        end
    end

    quad_gate_checker u_or (
        .CLK(CLK), .RST(RST), .START(st_or), .A(a_or), .B(b_or), .Y(y_or),
        .BUSY(busy_or), .DONE(done_or), .PASS(pass_or), .ERR_COUNT(err_or),
        .FAIL_VEC(fvec_or), .FAIL_MASK(fmask_or)
    );

    quad_gate_checker #(.SETTLE_CYCLES(2), .GATE_FN(2)) u_nand2 (
        .CLK(CLK), .RST(RST), .START(st_n2), .A(a_n2), .B(b_n2), .Y(y_n2),
        .BUSY(busy_n2), .DONE(done_n2), .PASS(pass_n2), .ERR_COUNT(err_n2),
        .FAIL_VEC(fvec_n2), .FAIL_MASK(fmask_n2)
    );

    quad_gate_checker #(.SETTLE_CYCLES(1), .GATE_FN(2)) u_nand1 (
        .CLK(CLK), .RST(RST), .START(st_n1), .A(a_n1), .B(b_n1), .Y(y_n1),
        .BUSY(busy_n1), .DONE(done_n1), .PASS(pass_n1), .ERR_COUNT(err_n1),
        .FAIL_VEC(fvec_n1), .FAIL_MASK(fmask_n1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] ab_hist [0:40];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic set_start(input int which, input logic val);
        case (which)
            0:       st_or = val;
            1:       st_n2 = val;
            default: st_n1 = val;
        endcase
    endtask

    function automatic logic done_of(input int which);
        case (which)
            0:       return done_or;
            1:       return done_n2;
            default: return done_n1;
        endcase
    endfunction

    // Pulse START for one edge (E0); cyc = number of negedges after E0 until DONE seen
    task automatic run(input int which, output int cyc);
        @(negedge CLK);
        set_start(which, 1'b1);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (i == 1) set_start(which, 1'b0);
            ab_hist[i] = {a_or, b_or};
            if (done_of(which)) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ab"},    {a_or, b_or}, 32'h0);
        check({tag, "_flags"}, {busy_or, done_or, pass_or}, 32'h0);
        check({tag, "_res"},   {err_or, fvec_or, fmask_or}, 32'h0);
    endtask

    initial begin
        int cyc;
        int n_done;
        int first_done;
        int dq[$];
        logic [7:0] exp_ab;

        repeat (3) @(negedge CLK);
        check_reset_vals("reset");
        RST = 1'b0;

        // Good OR, default parameters
        mode = 0;
        run(0, cyc);
        check("or_done_latency", cyc, 9);
        for (int i = 1; i <= 8; i++) begin
            case ((i - 1) / 2)
                0:       exp_ab = 8'h00;
                1:       exp_ab = 8'h0F;
                2:       exp_ab = 8'hF0;
                default: exp_ab = 8'hFF;
            endcase
            check($sformatf("or_ab_step%0d", i), ab_hist[i], exp_ab);
        end
        check("or_result", {pass_or, err_or, fvec_or, fmask_or}, {1'b1, 5'd0, 2'd0, 4'd0});
        check("or_busy_fin", busy_or, 1'b0);
        @(negedge CLK);
        check("or_done_one_cycle", done_or, 1'b0);

        // Gate 3 output stuck low
        mode = 1;
        run(0, cyc);
        check("stuck_result", {pass_or, err_or, fvec_or, fmask_or}, {1'b0, 5'd3, 2'd1, 4'b0100});
        repeat (5) @(negedge CLK);
        check("stuck_held", {pass_or, err_or, fvec_or, fmask_or}, {1'b0, 5'd3, 2'd1, 4'b0100});

        // AND device behind an OR checker
        mode = 2;
        run(0, cyc);
        check("wrongfn_result", {pass_or, err_or, fvec_or, fmask_or}, {1'b0, 5'd8, 2'd1, 4'b1111});

        // Lagging NAND: enough settle time at 2, first compare too early at 1
        run(1, cyc);
        check("nand2_latency", cyc, 9);
        check("nand2_result", {pass_n2, err_n2}, {1'b1, 5'd0});
        run(2, cyc);
        check("nand1_latency", cyc, 5);
        check("nand1_result", {pass_n1, fvec_n1, fmask_n1}, {1'b0, 2'd0, 4'b1111});

        // Reset during RUN, then a clean rerun
        mode = 0;
        @(negedge CLK);
        st_or = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            if (i == 1) st_or = 1'b0;
            if (i == 3) RST = 1'b1;
        end
        check_reset_vals("midrun_reset");
        RST = 1'b0;
        run(0, cyc);
        check("rerun_latency", cyc, 9);
        check("rerun_pass", {pass_or, err_or}, {1'b1, 5'd0});

        // START pulses during RUN (n=3) and FIN (n=9) are ignored
        @(negedge CLK);
        st_or = 1'b1;
        n_done = 0;
        first_done = -1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge CLK);
            st_or = (i == 3) || (i == 9);
            if (done_or) begin
                n_done++;
                if (first_done < 0) first_done = i;
            end
        end
        check("busy_start_first_done", first_done, 9);
        check("busy_start_done_count", n_done, 1);
        check("busy_start_idle", busy_or, 1'b0);

        // START held high: back-to-back runs every 10 cycles, results cleared per run
        mode = 1;
        @(negedge CLK);
        st_or = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (done_or) begin
                dq.push_back(i);
                check($sformatf("held_err_run%0d", dq.size()), err_or, 5'd3);
            end
        end
        st_or = 1'b0;
        check("held_done_count", dq.size(), 4);
        if (dq.size() >= 3) begin
            check("held_first_done", dq[0], 9);
            check("held_period1", dq[1] - dq[0], 10);
            check("held_period2", dq[2] - dq[1], 10);
        end
        repeat (12) @(negedge CLK);
        check("held_end_idle", {busy_or, done_or}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
